// File: rtl/riscv_v_pkg.sv
// Shared RISC-V V types and helpers: operand-size encoding plus the
// sequential extend stage's beat index, FSM states and decode functions.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_VALID_OSIZES = 5;
  localparam int RISCV_V_EXT_PART_W       = $clog2(2**(RISCV_V_NUM_VALID_OSIZES-1));
  localparam int OSIZE_IDX_W              = $clog2(RISCV_V_NUM_VALID_OSIZES);

  typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector_t;
  typedef logic [OSIZE_IDX_W-1:0]              osize_idx_t;
  typedef logic [RISCV_V_EXT_PART_W-1:0]       riscv_v_ext_part_t;

  typedef enum logic {IDLE, BUSY} riscv_v_ext_state_e;

  typedef struct packed {
    logic       illegal;
    osize_idx_t idx;
  } osize_dec_t;

  function automatic osize_dec_t osize_idx(input osize_vector_t v);
    osize_dec_t r;
    r.illegal = !$onehot(v);
    r.idx     = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++)
      if (v[i]) r.idx = osize_idx_t'(i);
    return r;
  endfunction

  // Returns F-1, the index of the final beat; caller guarantees d > s.
  function automatic riscv_v_ext_part_t ext_factor(input osize_idx_t s, input osize_idx_t d);
    return riscv_v_ext_part_t'((1 << (d - s)) - 1);
  endfunction

endpackage

// File: rtl/riscv_v_ext_slice.sv
// Combinational extender: builds beat k of a vzext/vsext of the source
// vector for source size index s and destination size index d.
module riscv_v_ext_slice
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int PART_W     = RISCV_V_EXT_PART_W
) (
  input  logic [DATA_WIDTH-1:0] src,
  input  osize_idx_t            src_idx,
  input  osize_idx_t            dst_idx,
  input  logic [PART_W-1:0]     part,
  input  logic                  is_sign,
  output logic [DATA_WIDTH-1:0] beat
);

  localparam int DW_LOG = $clog2(DATA_WIDTH);

  always_comb begin
    int   src_log;
    int   dst_log;
    int   off;
    int   elem;
    int   pos;
    logic bit_v;
    beat    = '0;
    src_log = int'(src_idx) + 3;
    dst_log = int'(dst_idx) + 3;
    off     = 0;
    elem    = 0;
    pos     = 0;
    bit_v   = 1'b0;
    // Every destination bit either copies a source bit or replicates the
    // source element MSB; destination element j of beat k reads source
    // element k*(DATA_WIDTH/dst_bits)+j.
    if (dst_log <= DW_LOG && src_log < dst_log) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        off  = b & ((1 << dst_log) - 1);
        elem = (int'(part) << (DW_LOG - dst_log)) + (b >> dst_log);
        pos  = (elem << src_log) + ((off < (1 << src_log)) ? off : (1 << src_log) - 1);
        if (pos < DATA_WIDTH) begin
          bit_v   = src[pos[DW_LOG-1:0]];
          beat[b] = (off < (1 << src_log)) ? bit_v : (is_sign & bit_v);
        end
      end
    end
  end

endmodule

// File: rtl/riscv_v_ext_seq.sv
// Sequential vzext/vsext.vf2..vf16: one source vector in, F extended beats out.
// Optional registered output stage enabled by defining RISCV_V_EXT_OUT_REG_EN.
module riscv_v_ext_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
  parameter int PART_W     = $clog2(2**(NUM_OSIZES-1))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_zero_ext,
  input  logic                  in_is_sign_ext,
  input  osize_vector_t         in_src_osize,
  input  osize_vector_t         in_dst_osize,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PART_W-1:0]     out_part,
  output logic                  out_last,
  output logic                  out_err
);

  riscv_v_ext_state_e    state_q, state_d;
  logic [PART_W-1:0]     part_q, part_d, last_q;
  logic [DATA_WIDTH-1:0] src_q, slice_beat, ext_data;
  logic                  sign_q, err_q;
  osize_idx_t            s_q, d_q;
  osize_dec_t            src_dec, dst_dec;
  logic                  req_err;
  riscv_v_ext_part_t     req_last;
  logic                  busy, ext_last, advance, accept;

  assign busy     = (state_q == BUSY);
  assign ext_last = (part_q == last_q);
  assign ext_data = err_q ? '0 : slice_beat;
  assign accept   = in_valid & in_ready;

  always_comb begin
    src_dec  = osize_idx(in_src_osize);
    dst_dec  = osize_idx(in_dst_osize);
    req_err  = src_dec.illegal | dst_dec.illegal | (dst_dec.idx <= src_dec.idx) |
               (in_is_zero_ext == in_is_sign_ext);
    req_last = req_err ? '0 : ext_factor(src_dec.idx, dst_dec.idx);
  end

  riscv_v_ext_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .PART_W     (PART_W)
  ) u_slice (
    .src     (src_q),
    .src_idx (s_q),
    .dst_idx (d_q),
    .part    (part_q),
    .is_sign (sign_q),
    .beat    (slice_beat)
  );

`ifdef RISCV_V_EXT_OUT_REG_EN
  logic                  ov_q, ol_q, oe_q, stage_load;
  logic [DATA_WIDTH-1:0] od_q;
  logic [PART_W-1:0]     op_q;

  assign stage_load = !ov_q | out_ready;
  assign advance    = busy & stage_load;
  assign in_ready   = !busy | (advance & ext_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      op_q <= '0;
      ol_q <= 1'b0;
      oe_q <= 1'b0;
    end else if (stage_load) begin
      ov_q <= busy;
      od_q <= busy ? ext_data : '0;
      op_q <= part_q;
      ol_q <= busy & ext_last;
      oe_q <= busy & err_q;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_part  = op_q;
  assign out_last  = ol_q;
  assign out_err   = oe_q;
`else
  assign advance   = busy & out_ready;
  assign in_ready  = !busy | (advance & ext_last);
  assign out_valid = busy;
  assign out_data  = busy ? ext_data : '0;
  assign out_part  = part_q;
  assign out_last  = busy & ext_last;
  assign out_err   = busy & err_q;
`endif

  // NOTE: defaults first so every path assigns every output; no latches inferred.
  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    if (advance) begin
      if (ext_last) begin
        part_d  = '0;
        state_d = IDLE;
      end else begin
        part_d = part_q + 1'b1;
      end
    end
    // A source accepted on the last beat's edge restarts without a bubble.
    if (accept) begin
      state_d = BUSY;
      part_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      part_q  <= '0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
      s_q    <= '0;
      d_q    <= '0;
      last_q <= '0;
    end else if (accept) begin
      src_q  <= in_data;
      sign_q <= in_is_sign_ext;
      err_q  <= req_err;
      s_q    <= src_dec.idx;
      d_q    <= dst_dec.idx;
      last_q <= PART_W'(req_last);
    end
  end

endmodule

// File: tb/tb_riscv_v_ext_seq.sv
// Directed self-checking bench for riscv_v_ext_seq (default build, latency 1).
module tb_riscv_v_ext_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_is_zero_ext = 1'b0;
  logic         in_is_sign_ext = 1'b0;
  logic [4:0]   in_src_osize = '0;
  logic [4:0]   in_dst_osize = '0;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_part;
  logic         out_last;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  riscv_v_ext_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_zero_ext (in_is_zero_ext),
    .in_is_sign_ext (in_is_sign_ext),
    .in_src_osize   (in_src_osize),
    .in_dst_osize   (in_dst_osize),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_part       (out_part),
    .out_last       (out_last),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [4:0] src, input logic [4:0] dst,
                           input logic z, input logic s, input logic [127:0] d);
    in_valid       = 1'b1;
    in_src_osize   = src;
    in_dst_osize   = dst;
    in_is_zero_ext = z;
    in_is_sign_ext = s;
    in_data        = d;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 128'(out_valid), 128'd1);
  endtask

  // Source pattern A: byte i = 0x80+i.
  function automatic logic [127:0] pat_a();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(8'h80 + i);
    return v;
  endfunction

  // Source pattern B: halfword i = 0x8000|i for odd i, i for even i.
  function automatic logic [127:0] pat_b();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = (i % 2 == 1) ? 16'(16'h8000 | i) : 16'(i);
    return v;
  endfunction

  function automatic logic [127:0] exp_sext8_16(input int k);
    logic [127:0] v;
    for (int j = 0; j < 8; j++) v[16*j +: 16] = 16'(16'hFF80 + 8*k + j);
    return v;
  endfunction

  function automatic logic [127:0] exp_zext8_64(input int k);
    logic [127:0] v;
    v[63:0]   = 64'(8'h80 + 2*k);
    v[127:64] = 64'(8'h81 + 2*k);
    return v;
  endfunction

  function automatic logic [127:0] exp_zext8_32(input int k);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[32*j +: 32] = 32'(8'h80 + 4*k + j);
    return v;
  endfunction

  function automatic logic [127:0] exp_sext16_32(input int k);
    logic [127:0] v;
    int e;
    for (int j = 0; j < 4; j++) begin
      e = 4*k + j;
      v[32*j +: 32] = (e % 2 == 1) ? (32'hFFFF_8000 | 32'(e)) : 32'(e);
    end
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] bp_pat;
    int k;
    int cyc;
    bp_pat = 4'b1001;

    // Reset state
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_out_part",  128'(out_part),  128'd0);
    check("rst_out_last",  128'(out_last),  128'd0);
    check("rst_out_err",   128'(out_err),   128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);

    // sext 8->16
    drive_req(5'b00001, 5'b00010, 1'b0, 1'b1, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    check("s816_b0_data", out_data,        exp_sext8_16(0));
    check("s816_b0_part", 128'(out_part),  128'd0);
    check("s816_b0_last", 128'(out_last),  128'd0);
    @(negedge clk);
    check("s816_b1_data", out_data,        exp_sext8_16(1));
    check("s816_b1_part", 128'(out_part),  128'd1);
    check("s816_b1_last", 128'(out_last),  128'd1);
    check("s816_b1_err",  128'(out_err),   128'd0);
    @(negedge clk);
    check("s816_done",    128'(out_valid), 128'd0);

    // zext 8->64, eight beats
    drive_req(5'b00001, 5'b01000, 1'b1, 1'b0, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    for (int b = 0; b < 8; b++) begin
      check("z864_data", out_data,       exp_zext8_64(b));
      check("z864_part", 128'(out_part), 128'(b));
      check("z864_last", 128'(out_last), 128'(b == 7));
      @(negedge clk);
    end
    check("z864_done", 128'(out_valid), 128'd0);

    // Back-to-back: second source accepted on first's last beat
    drive_req(5'b00001, 5'b00010, 1'b0, 1'b1, pat_a());
    @(negedge clk);
    drive_req(5'b00010, 5'b00100, 1'b0, 1'b1, pat_b());
    check("b2b_b0_data",  out_data,        exp_sext8_16(0));
    check("b2b_b0_ready", 128'(in_ready),  128'd0);
    @(negedge clk);
    check("b2b_b1_last",  128'(out_last),  128'd1);
    check("b2b_b1_ready", 128'(in_ready),  128'd1);
    @(negedge clk); idle_in();
    check("b2b_nobubble", 128'(out_valid), 128'd1);
    check("b2b_n0_part",  128'(out_part),  128'd0);
    check("b2b_n0_data",  out_data,        exp_sext16_32(0));
    @(negedge clk);
    check("b2b_n1_data",  out_data,        exp_sext16_32(1));
    check("b2b_n1_last",  128'(out_last),  128'd1);
    @(negedge clk);
    check("b2b_done",     128'(out_valid), 128'd0);

    // Backpressure on zext 8->32 with out_ready 1,0,0,1,...
    drive_req(5'b00001, 5'b00100, 1'b1, 1'b0, pat_a());
    @(negedge clk); idle_in();
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      out_ready = bp_pat[3 - (cyc % 4)];
      if (out_valid) begin
        check("bp_data", out_data,       exp_zext8_32(k));
        check("bp_part", 128'(out_part), 128'(k));
        check("bp_last", 128'(out_last), 128'(k == 3));
        if (out_ready) k++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_beats", 128'(k),         128'd4);
    check("bp_done",  128'(out_valid), 128'd0);

    // Illegal: dst smaller than src
    drive_req(5'b00010, 5'b00001, 1'b0, 1'b1, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    check("ill_sz_data", out_data,       128'd0);
    check("ill_sz_err",  128'(out_err),  128'd1);
    check("ill_sz_last", 128'(out_last), 128'd1);
    check("ill_sz_part", 128'(out_part), 128'd0);
    @(negedge clk);
    check("ill_sz_done",  128'(out_valid), 128'd0);
    check("ill_sz_ready", 128'(in_ready),  128'd1);

    // Illegal: both extension flags set
    drive_req(5'b00001, 5'b00010, 1'b1, 1'b1, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    check("ill_fl_data", out_data,       128'd0);
    check("ill_fl_err",  128'(out_err),  128'd1);
    check("ill_fl_last", 128'(out_last), 128'd1);
    @(negedge clk);
    check("ill_fl_done", 128'(out_valid), 128'd0);

    // Reset asserted during beat 3 of an F=8 transfer
    drive_req(5'b00001, 5'b01000, 1'b1, 1'b0, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    repeat (3) @(negedge clk);
    check("rmid_part3", 128'(out_part), 128'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_valid", 128'(out_valid), 128'd0);
    check("rmid_part",  128'(out_part),  128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmid_ready", 128'(in_ready),  128'd1);
    check("rmid_idle",  128'(out_valid), 128'd0);
    drive_req(5'b00001, 5'b00010, 1'b0, 1'b1, pat_a());
    @(negedge clk); idle_in();
    wait_valid(4);
    check("rmid_new_part", 128'(out_part), 128'd0);
    check("rmid_new_data", out_data,       exp_sext8_16(0));
    @(negedge clk);
    check("rmid_new_last", 128'(out_last), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
